// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu: MEM-stage load/store unit with a word-organised data RAM.
//
// Stores complete in the accept cycle with per-byte lane enables. Loads capture the
// address and func3, wait RD_LAT cycles in StLoad, then present the extended result
// on me_mem_data with a one-cycle me_mem_data_vld pulse. me_ready is low while a load
// is in flight.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-low reset
//   me_valid/me_ready op handshake; me_ready is high whenever the FSM is idle
//   me_mem_read/write load / store request (both set: store wins, read dropped)
//   me_func3_code     access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   me_alu_o          byte address; bits above the RAM index are ignored
//   me_regs_data2     store data; w_regs_data replaces it when forward_data is set
//   me_mem_data       extended load result, held until the next load completes
//   me_mem_data_vld   one-cycle pulse when me_mem_data is new
//   me_misalign       (STAGE_MEM_MISALIGN_TRAP_EN only) pulse on a misaligned access
//
// Optional feature macro: STAGE_MEM_MISALIGN_TRAP_EN. When defined, misaligned half/word
// accesses are trapped and dropped; otherwise they are silently aligned down.
module stage_mem_lsu #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            me_valid,
  output logic            me_ready,
  input  logic            me_mem_read,
  input  logic            me_mem_write,
  input  logic [2:0]      me_func3_code,
  input  logic [XLEN-1:0] me_alu_o,
  input  logic [XLEN-1:0] me_regs_data2,
  input  logic            forward_data,
  input  logic [XLEN-1:0] w_regs_data,
  output logic [XLEN-1:0] me_mem_data,
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
  output logic            me_mem_data_vld,
  output logic            me_misalign
`else
  output logic            me_mem_data_vld
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // 011/110/111 fall into the word class, matching LW behaviour.
  function automatic size_e size_of(input logic [2:0] f3);
    size_e sz;
    case (f3[1:0])
      2'b00:   sz = SzByte;
      2'b01:   sz = SzHalf;
      default: sz = SzWord;
    endcase
    return sz;
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW+1:0]   addr_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] data_q;
  logic            vld_q;

  logic [XLEN-1:0] mem [DEPTH];

  size_e           acc_size;
  size_e           ld_size;
  logic            misalign_hit;
  logic            store_en;
  logic            load_acc;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] wlane;
  logic [3:0]      be;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ld_ext;

  // Address bits above the RAM index wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^me_alu_o[XLEN-1:AW+2];

  assign me_ready        = (state_q == StIdle);
  assign me_mem_data     = data_q;
  assign me_mem_data_vld = vld_q;
  assign acc_size        = size_of(me_func3_code);
  assign ld_size         = size_of(func3_q);

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_hit = 1'b0;
    unique case (acc_size)
      SzHalf:  misalign_hit = me_alu_o[0];
      SzWord:  misalign_hit = |me_alu_o[1:0];
      default: misalign_hit = 1'b0;
    endcase
  end

  assign me_misalign = rst & me_valid & me_ready & (me_mem_read | me_mem_write) & misalign_hit;
`else
  // Sub-word alignment is implicit: lane selection never looks at the dropped bits.
  assign misalign_hit = 1'b0;
`endif

  // A store takes priority over a simultaneous read request.
  assign store_en = rst & me_valid & me_ready & me_mem_write & ~misalign_hit;
  assign load_acc = me_valid & me_ready & me_mem_read & ~me_mem_write & ~misalign_hit;

  // Store lane placement: replicate the sub-word across lanes, let be pick the target.
  always_comb begin
    wdata = forward_data ? w_regs_data : me_regs_data2;
    wlane = wdata;
    be    = 4'b1111;
    unique case (acc_size)
      SzByte: begin
        wlane = {4{wdata[7:0]}};
        be    = 4'b0001 << me_alu_o[1:0];
      end
      SzHalf: begin
        wlane = {2{wdata[15:0]}};
        be    = me_alu_o[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wlane = wdata;
        be    = 4'b1111;
      end
    endcase
  end

  assign widx = me_alu_o[AW+1:2];

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  // Load lane extraction from the captured address; func3[2] selects zero extension.
  always_comb begin
    rd_word = mem[addr_q[AW+1:2]];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_ext  = rd_word;
    unique case (ld_size)
      SzByte:  ld_ext = {{24{~func3_q[2] & rd_byte[7]}}, rd_byte};
      SzHalf:  ld_ext = {{16{~func3_q[2] & rd_half[15]}}, rd_half};
      default: ld_ext = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      func3_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_acc) begin
            state_q <= StLoad;
            cnt_q   <= CW'(RD_LAT - 1);
            addr_q  <= me_alu_o[AW+1:0];
            func3_q <= me_func3_code;
          end
        end
        StLoad: begin
          // The read lands on the edge that leaves StLoad, so vld trails accept by RD_LAT.
          if (cnt_q == '0) begin
            state_q <= StIdle;
            vld_q   <= 1'b1;
            data_q  <= ld_ext;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
